// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM encoding, command bytes and frame constants.
// Imported by the host transmitter and the line synchronizer (also reused by the receive path).
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;
  localparam logic [2:0] ST_ACK       = 3'd6;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd7;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  localparam int PS2_FRAME_FALLS = 11;

  typedef struct packed {
    logic clk;
    logic data;
  } ps2_lines_t;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw ps2_clock/ps2_data pins plus a registered
// falling-edge strobe on the synchronized clock.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output ps2_lines_t o_lines,
  output logic       o_clk_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;
  logic       r_clk_fall;

  // Reset to the idle (pulled-up) level so leaving reset never fakes an edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_clk_fall  <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[1];
      r_clk_fall  <= r_clk_prev & ~r_clk_sync[1];
    end
  end

  assign o_lines.clk  = r_clk_sync[1];
  assign o_lines.data = r_data_sync[1];
  assign o_clk_fall   = r_clk_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first, odd parity,
// stop and device ack, with a per-edge timeout. Drives the shared lines open-drain via *_oe.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_cmd_data,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_rx_inhibit,
  output logic       o_tx_done,
  output logic       o_tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // The last inhibit cycle overlaps the start bit, so INHIBIT itself lasts one cycle less.
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [7:0]       r_byte;
  logic             r_parity;
  logic [3:0]       r_bit_idx;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_tx_done;
  logic             r_tx_error;

  ps2_lines_t       w_lines;
  logic             w_fall;
  logic             w_watch;
  logic             w_timed_out;

  ps2_line_sync u_sync (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_ps2_clk  (i_ps2_clk_in),
    .i_ps2_data (i_ps2_data_in),
    .o_lines    (w_lines),
    .o_clk_fall (w_fall)
  );

  assign w_watch     = (r_state != ST_IDLE) && (r_state != ST_INHIBIT);
  assign w_timed_out = w_watch && !w_fall && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_bit_idx  <= '0;
      r_inh_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
    end else begin
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;

      if (w_watch) begin
        if (w_fall) begin
          r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != TMO_LAST) begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_byte    <= i_cmd_data;
            r_parity  <= ps2_odd_parity(i_cmd_data);
            r_inh_cnt <= '0;
            r_clk_oe  <= 1'b1;
            r_state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            r_data_oe <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= ST_RTS;
          end else begin
            r_inh_cnt <= r_inh_cnt + INH_W'(1);
          end
        end
        ST_RTS: begin
          r_clk_oe <= 1'b0;
          if (w_fall) begin
            r_data_oe <= ~r_byte[0];
            r_bit_idx <= 4'd1;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_fall) begin
            r_data_oe <= ~r_byte[r_bit_idx[2:0]];
            r_bit_idx <= r_bit_idx + 4'd1;
            if (r_bit_idx == 4'd7) begin
              r_state <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (w_fall) begin
            r_data_oe <= ~r_parity;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_fall) begin
            r_data_oe <= 1'b0;
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (w_fall) begin
            if (w_lines.data) begin
              r_tx_error <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (w_lines.clk && w_lines.data) begin
            r_tx_done <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // A stalled device overrides whatever the state above decided.
      if (w_timed_out) begin
        r_clk_oe   <= 1'b0;
        r_data_oe  <= 1'b0;
        r_tx_done  <= 1'b0;
        r_tx_error <= 1'b1;
        r_state    <= ST_IDLE;
      end
    end
  end

  assign o_cmd_ready   = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_rx_inhibit  = o_busy;
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;
  assign o_tx_done     = r_tx_done;
  assign o_tx_error    = r_tx_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and the
// captured bits are compared with frames built from the byte by plain arithmetic.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 1000;
  localparam int TMO  = 2000;
  localparam int HALF = 100;
  localparam int LIM  = INH + TMO + 30 * HALF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       cmd_ready, clk_oe, data_oe, busy, rx_inh, tx_done, tx_err;
  logic       clk_line, data_line;

  assign clk_line  = ~(clk_oe | dev_clk_low);
  assign data_line = ~(data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_cmd_data    (cmd_data),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_ps2_clk_in  (clk_line),
    .i_ps2_data_in (data_line),
    .o_ps2_clk_oe  (clk_oe),
    .o_ps2_data_oe (data_oe),
    .o_busy        (busy),
    .o_rx_inhibit  (rx_inh),
    .o_tx_done     (tx_done),
    .o_tx_error    (tx_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0, n_clkoe = 0, n_done = 0, n_err = 0, n_both = 0, n_inh_bad = 0, n_inh_hi = 0;
  int rts_cyc = -1, clkoe_fall_cyc = -1, done_cyc = -1, err_cyc = -1, accept_cyc = -1;
  logic p_clk_oe = 1'b0, p_data_oe = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    p_clk_oe  <= clk_oe;
    p_data_oe <= data_oe;
    p_busy    <= busy;
    if (clk_oe) n_clkoe <= n_clkoe + 1;
    if (tx_done) begin n_done <= n_done + 1; done_cyc <= cyc; end
    if (tx_err) begin n_err <= n_err + 1; err_cyc <= cyc; end
    if (tx_done && tx_err) n_both <= n_both + 1;
    if (rx_inh !== busy || cmd_ready !== !busy) n_inh_bad <= n_inh_bad + 1;
    if (rx_inh) n_inh_hi <= n_inh_hi + 1;
    if (data_oe && !p_data_oe && clk_oe) rts_cyc <= cyc;
    if (!clk_oe && p_clk_oe) clkoe_fall_cyc <= cyc;
    if (busy && !p_busy) accept_cyc <= cyc;
  end

  // Expected frame as the device sees it: {stop, parity, data, start}.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Device: waits for request-to-send, then clocks 11 falls; stop_after>0 abandons mid-frame.
  task automatic device_xfer(input bit do_ack, input int stop_after,
                             output logic [10:0] got, output bit ok);
    int n;
    n   = 0;
    got = '0;
    ok  = 1'b0;
    while (!(clk_oe === 1'b0 && data_oe === 1'b1) && n < 4 * INH) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * INH) return;
    repeat (HALF) @(negedge clk);
    got[0] = data_line;
    for (int k = 1; k <= PS2_FRAME_FALLS; k++) begin
      if (k == PS2_FRAME_FALLS) begin
        dev_data_low = do_ack;
        repeat (10) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (k == stop_after) begin
        repeat (10) @(negedge clk);
        ok = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) got[k] = data_line;
      if (k == PS2_FRAME_FALLS) dev_data_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    ok = 1'b1;
  endtask

  task automatic wait_end(input int d0, input int e0, output bit ok);
    int n;
    n = 0;
    while (n_done == d0 && n_err == e0 && n < LIM) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (n < LIM);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({clk_oe, data_oe, cmd_ready, busy, rx_inh, tx_done, tx_err} !== 7'b0010000) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected 0010000",
               {clk_oe, data_oe, cmd_ready, busy, rx_inh, tx_done, tx_err});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
  endtask

  task automatic test_send_ed;
    logic [10:0] f;
    bit dok, eok;
    int c0, d0, e0;
    c0 = n_clkoe; d0 = n_done; e0 = n_err;
    issue(8'hED);
    device_xfer(1'b1, 0, f, dok);
    wait_end(d0, e0, eok);
    n_cmp++;
    if (!(dok && eok)) begin n_bad++; $display("FAIL ed_handshake: dev_ok %0d end_ok %0d expected 1 1", dok, eok); end
    n_cmp++;
    if (f !== frame_of(8'hED)) begin n_bad++; $display("FAIL ed_frame: got %b expected %b", f, frame_of(8'hED)); end
    n_cmp++;
    if (n_clkoe - c0 != INH) begin n_bad++; $display("FAIL ed_inhibit_len: got %0d expected %0d", n_clkoe - c0, INH); end
    n_cmp++;
    if (clkoe_fall_cyc - rts_cyc != 1) begin
      n_bad++; $display("FAIL ed_overlap: got %0d expected 1", clkoe_fall_cyc - rts_cyc);
    end
    n_cmp++;
    if (n_done - d0 != 1 || n_err != e0) begin
      n_bad++; $display("FAIL ed_pulses: done %0d err %0d expected 1 0", n_done - d0, n_err - e0);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({cmd_ready, busy, clk_oe, data_oe} !== 4'b1000) begin
      n_bad++; $display("FAIL ed_idle: got %b expected 1000", {cmd_ready, busy, clk_oe, data_oe});
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] f1, f2;
    bit ok1, ok2, eo1, eo2;
    int d0, dc1, n;
    d0 = n_done;
    @(negedge clk);
    cmd_data = 8'h00; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_data = 8'h01;
    device_xfer(1'b1, 0, f1, ok1);
    wait_end(d0, n_err, eo1);
    dc1 = done_cyc;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); #1; n++; end
    cmd_valid = 1'b0;
    n_cmp++;
    if (accept_cyc != dc1 + 1) begin
      n_bad++; $display("FAIL b2b_accept: got cycle %0d expected %0d", accept_cyc, dc1 + 1);
    end
    device_xfer(1'b1, 0, f2, ok2);
    wait_end(d0 + 1, n_err, eo2);
    n_cmp++;
    if (!(ok1 && ok2 && eo1 && eo2)) begin n_bad++; $display("FAIL b2b_handshake: got %b expected 1111", {ok1, ok2, eo1, eo2}); end
    n_cmp++;
    if (f1 !== frame_of(8'h00) || f1[9] !== 1'b1) begin n_bad++; $display("FAIL b2b_frame0: got %b expected %b", f1, frame_of(8'h00)); end
    n_cmp++;
    if (f2 !== frame_of(8'h01) || f2[9] !== 1'b0) begin n_bad++; $display("FAIL b2b_frame1: got %b expected %b", f2, frame_of(8'h01)); end
    n_cmp++;
    if (n_done - d0 != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", n_done - d0); end
  endtask

  task automatic test_nack;
    logic [10:0] f;
    bit dok, eok;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    issue(8'hFF);
    device_xfer(1'b0, 0, f, dok);
    wait_end(d0, e0, eok);
    repeat (3 * HALF) @(negedge clk);
    #1;
    n_cmp++;
    if (n_err - e0 != 1 || n_done != d0) begin
      n_bad++; $display("FAIL nack_pulses: err %0d done %0d expected 1 0", n_err - e0, n_done - d0);
    end
    n_cmp++;
    if (f !== frame_of(8'hFF)) begin n_bad++; $display("FAIL nack_frame: got %b expected %b", f, frame_of(8'hFF)); end
    n_cmp++;
    if ({cmd_ready, busy, clk_oe, data_oe} !== 4'b1000) begin
      n_bad++; $display("FAIL nack_idle: got %b expected 1000", {cmd_ready, busy, clk_oe, data_oe});
    end
  endtask

  task automatic test_timeout;
    bit eok;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    issue(8'h3C);
    wait_end(d0, e0, eok);
    n_cmp++;
    if (!eok || n_err - e0 != 1 || n_done != d0) begin
      n_bad++; $display("FAIL tmo_pulses: ended %0d err %0d done %0d expected 1 1 0", eok, n_err - e0, n_done - d0);
    end
    n_cmp++;
    if (err_cyc - rts_cyc != TMO) begin n_bad++; $display("FAIL tmo_latency: got %0d expected %0d", err_cyc - rts_cyc, TMO); end
    n_cmp++;
    if ({clk_oe, data_oe, cmd_ready} !== 3'b001) begin
      n_bad++; $display("FAIL tmo_release: got %b expected 001", {clk_oe, data_oe, cmd_ready});
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] f;
    bit dok, eok;
    int d0;
    issue(PS2_CMD_ECHO);
    device_xfer(1'b1, 4, f, dok);
    @(negedge clk);
    #1;
    n_cmp++;
    if (!dok || busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: dev_ok %0d busy %b expected 1 1", dok, busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({clk_oe, data_oe, busy, cmd_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL rstmid_async: got %b expected 0001", {clk_oe, data_oe, busy, cmd_ready});
    end
    @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    d0 = n_done;
    issue(PS2_CMD_ECHO);
    device_xfer(1'b1, 0, f, dok);
    wait_end(d0, n_err, eok);
    n_cmp++;
    if (!(dok && eok) || f !== frame_of(8'hEE) || n_done - d0 != 1) begin
      n_bad++; $display("FAIL rstmid_retry: got %b done %0d expected %b done 1", f, n_done - d0, frame_of(8'hEE));
    end
  endtask

  task automatic test_ignore_busy;
    logic [10:0] f;
    bit dok, eok;
    logic rdy;
    int d0, i0, h0;
    d0 = n_done; i0 = n_inh_bad; h0 = n_inh_hi;
    rdy = 1'bx;
    issue(PS2_CMD_SET_LEDS);
    fork
      device_xfer(1'b1, 0, f, dok);
      begin
        repeat (INH + 7 * HALF) @(negedge clk);
        #1;
        rdy = cmd_ready;
        cmd_data = 8'h55; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
      end
    join
    wait_end(d0, n_err, eok);
    n_cmp++;
    if (rdy !== 1'b0) begin n_bad++; $display("FAIL ign_ready: got %b expected 0", rdy); end
    n_cmp++;
    if (!(dok && eok) || f !== frame_of(8'hED)) begin n_bad++; $display("FAIL ign_frame: got %b expected %b", f, frame_of(8'hED)); end
    n_cmp++;
    if (n_inh_hi - h0 != done_cyc - accept_cyc || n_inh_bad != i0) begin
      n_bad++; $display("FAIL ign_inhibit: high %0d cycles expected %0d, mismatched %0d", n_inh_hi - h0, done_cyc - accept_cyc, n_inh_bad - i0);
    end
    repeat (2 * HALF) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || n_done - d0 != 1) begin n_bad++; $display("FAIL ign_single: busy %b done %0d expected 0 1", busy, n_done - d0); end
  endtask

  task automatic test_random;
    logic [10:0] f;
    logic [7:0] d;
    bit dok, eok;
    int d0, c0;
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      d0 = n_done; c0 = n_clkoe;
      issue(d);
      device_xfer(1'b1, 0, f, dok);
      wait_end(d0, n_err, eok);
      n_cmp++;
      if (!(dok && eok) || f !== frame_of(d) || n_done - d0 != 1 || n_clkoe - c0 != INH) begin
        n_bad++; $display("FAIL rand_frame[%0d]: byte %h got %b done %0d inh %0d expected %b 1 %0d",
                          i, d, f, n_done - d0, n_clkoe - c0, frame_of(d), INH);
      end
    end
  endtask

  initial begin
    test_reset;
    test_send_ed;
    test_back_to_back;
    test_nack;
    test_timeout;
    test_reset_mid;
    test_ignore_busy;
    test_random;
    n_cmp++;
    if (n_both != 0 || n_inh_bad != 0) begin
      n_bad++; $display("FAIL global_invariants: both %0d inhibit_mismatch %0d expected 0 0", n_both, n_inh_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
